game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 146 ++++++++++++++
 tb/tb_game_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Serve/play/miss/win sequencer for the brick-breaker game.
// Optional pause support is compiled in with GAME_SEQUENCER_PAUSE_EN.
module game_sequencer #(
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 4,
    parameter int MISS_ROW    = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [55:0] Bricks,
    input  logic [3:0]  Ball_rowIndex,
`ifdef GAME_SEQUENCER_PAUSE_EN
    input  logic        pause,
`endif
    output logic        ball_run,
    output logic        ball_serve,
    output logic        bricks_rst_n,
    output logic [1:0]  lives,
    output logic [2:0]  state,
    output logic        win,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        WIN   = 3'd4,
`ifdef GAME_SEQUENCER_PAUSE_EN
        OVER  = 3'd5,
        PAUSE = 3'd6
`else
        OVER  = 3'd5
`endif
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [2:0] SERVE_LEN  = 3'(SERVE_TICKS);
    localparam logic [3:0] MISS_IDX   = 4'(MISS_ROW);

    state_t     cur_state, nxt_state;
    logic [1:0] lives_nxt;
    logic [2:0] serve_cnt, serve_cnt_nxt;
    logic       serve_nxt, bricks_rst_n_nxt;
    logic       miss_hit, board_clear;

    assign state       = cur_state;
    assign board_clear = (Bricks == 56'd0);
    assign miss_hit    = tick && (Ball_rowIndex == MISS_IDX);

`ifdef GAME_SEQUENCER_PAUSE_EN
    logic pause_q, pause_rise;

    assign pause_rise = pause && !pause_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pause_q <= 1'b0;
        else
            pause_q <= pause;
    end
`endif

    // Every output is registered from the next-state decision so it lines up with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state    <= IDLE;
            lives        <= 2'd0;
            serve_cnt    <= 3'd0;
            ball_run     <= 1'b0;
            ball_serve   <= 1'b0;
            bricks_rst_n <= 1'b1;
            win          <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            lives        <= lives_nxt;
            serve_cnt    <= serve_cnt_nxt;
            ball_run     <= (nxt_state == PLAY);
            ball_serve   <= serve_nxt;
            bricks_rst_n <= bricks_rst_n_nxt;
            win          <= (nxt_state == WIN);
            game_over    <= (nxt_state == OVER);
        end
    end

    always_comb begin
        nxt_state        = cur_state;
        lives_nxt        = lives;
        serve_cnt_nxt    = serve_cnt;
        serve_nxt        = 1'b0;
        bricks_rst_n_nxt = 1'b1;
        case (cur_state)
            IDLE, WIN, OVER: begin
                if (start) begin
                    nxt_state        = SERVE;
                    serve_nxt        = 1'b1;
                    bricks_rst_n_nxt = 1'b0;
                    lives_nxt        = LIVES_INIT;
                    serve_cnt_nxt    = 3'd0;
                end
            end
            SERVE: begin
                if (tick) begin
                    serve_cnt_nxt = serve_cnt + 3'd1;
                    if (serve_cnt + 3'd1 == SERVE_LEN)
                        nxt_state = PLAY;
                end
            end
            PLAY: begin
                // An empty board wins even when the ball is lost in the same cycle.
`ifdef GAME_SEQUENCER_PAUSE_EN
                if (pause_rise)
                    nxt_state = PAUSE;
                else if (board_clear)
`else
                if (board_clear)
`endif
                    nxt_state = WIN;
                else if (miss_hit)
                    nxt_state = MISS;
            end
            MISS: begin
                lives_nxt = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                if (lives <= 2'd1) begin
                    nxt_state = OVER;
                end else begin
                    nxt_state     = SERVE;
                    serve_nxt     = 1'b1;
                    serve_cnt_nxt = 3'd0;
                end
            end
`ifdef GAME_SEQUENCER_PAUSE_EN
            PAUSE: begin
                if (pause_rise)
                    nxt_state = PLAY;
            end
`endif
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected outputs, a monitor compares them.
module tb_game_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;
    localparam logic [55:0] FULL   = {56{1'b1}};
    localparam logic [55:0] EMPTY  = 56'd0;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic       run;
        logic       serve;
        logic       brst;
        logic       win;
        logic       over;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        start;
    logic [55:0] bricks;
    logic [3:0]  row;
    logic        ball_run, ball_serve, bricks_rst_n, win, game_over;
    logic [1:0]  lives;
    logic [2:0]  state;
`ifdef GAME_SEQUENCER_PAUSE_EN
    logic        pause_in = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    string name_q[$];

    game_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .Bricks       (bricks),
        .Ball_rowIndex(row),
`ifdef GAME_SEQUENCER_PAUSE_EN
        .pause        (pause_in),
`endif
        .ball_run     (ball_run),
        .ball_serve   (ball_serve),
        .bricks_rst_n (bricks_rst_n),
        .lives        (lives),
        .state        (state),
        .win          (win),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    function automatic exp_t ex(input logic [2:0] st, input logic [1:0] lv, input logic run,
                                input logic serve, input logic brst, input logic w, input logic ov);
        exp_t e;
        e.st = st; e.lv = lv; e.run = run; e.serve = serve; e.brst = brst; e.win = w; e.over = ov;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        exp_t got;
        got = '{st: state, lv: lives, run: ball_run, serve: ball_serve,
                brst: bricks_rst_n, win: win, over: game_over};
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL %s: got st=%0d lv=%0d run=%b serve=%b brst_n=%b win=%b over=%b, expected st=%0d lv=%0d run=%b serve=%b brst_n=%b win=%b over=%b",
                     name, got.st, got.lv, got.run, got.serve, got.brst, got.win, got.over,
                     e.st, e.lv, e.run, e.serve, e.brst, e.win, e.over);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the expectation applies after the next rising edge.
    task automatic applyStimulus(input logic t, input logic s, input logic [55:0] b,
                                 input logic [3:0] r, input exp_t e, input string name);
        @(negedge clock);
        tick   = t;
        start  = s;
        bricks = b;
        row    = r;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic serveToPlay(input logic [1:0] lv);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, FULL, 4'd15, ex(S_SERVE, lv, 0, 0, 1, 0, 0), "serve_count");
        applyStimulus(1'b1, 1'b0, FULL, 4'd0, ex(S_PLAY, lv, 1, 0, 1, 0, 0), "serve_to_play");
    endtask

`ifdef GAME_SEQUENCER_PAUSE_EN
    task automatic pauseStep(input logic p, input logic t, input logic s, input logic [55:0] b,
                             input logic [3:0] r, input exp_t e, input string name);
        @(negedge clock);
        pause_in = p;
        tick     = t;
        start    = s;
        bricks   = b;
        row      = r;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask
`endif

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0)
                checkOutput(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        start  = 1'b0;
        bricks = FULL;
        row    = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_state", ex(S_IDLE, 0, 0, 0, 1, 0, 0));
        reset = 1'b0;

        applyStimulus(0, 0, FULL, 4'd0, ex(S_IDLE, 0, 0, 0, 1, 0, 0), "idle_wait");
        applyStimulus(0, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 1, 0, 0, 0), "start_serve");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_SERVE, 3, 0, 0, 1, 0, 0), "pulse_end");
        applyStimulus(1, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 0, 1, 0, 0), "serve_tick1_start_ignored");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_SERVE, 3, 0, 0, 1, 0, 0), "serve_gap");
        applyStimulus(1, 0, FULL, 4'd0, ex(S_SERVE, 3, 0, 0, 1, 0, 0), "serve_tick2");
        applyStimulus(1, 0, FULL, 4'd0, ex(S_SERVE, 3, 0, 0, 1, 0, 0), "serve_tick3");
        applyStimulus(1, 0, FULL, 4'd0, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "serve_tick4_play");
        applyStimulus(0, 1, FULL, 4'd15, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "play_start_and_row_no_tick");
        applyStimulus(1, 0, FULL, 4'd14, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "play_row14_tick");

        applyStimulus(1, 0, FULL, 4'd15, ex(S_MISS, 3, 0, 0, 1, 0, 0), "miss1");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_SERVE, 2, 0, 1, 1, 0, 0), "reserve_lives2");
        serveToPlay(2);
        applyStimulus(1, 0, FULL, 4'd15, ex(S_MISS, 2, 0, 0, 1, 0, 0), "miss2");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_SERVE, 1, 0, 1, 1, 0, 0), "reserve_lives1");
        serveToPlay(1);
        applyStimulus(1, 0, FULL, 4'd15, ex(S_MISS, 1, 0, 0, 1, 0, 0), "miss3");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_OVER, 0, 0, 0, 1, 0, 1), "game_over");
        applyStimulus(1, 0, FULL, 4'd15, ex(S_OVER, 0, 0, 0, 1, 0, 1), "over_hold");

        applyStimulus(0, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 1, 0, 0, 0), "restart_from_over");
        serveToPlay(3);
        applyStimulus(1, 0, EMPTY, 4'd15, ex(S_WIN, 3, 0, 0, 1, 1, 0), "win_beats_miss");
        applyStimulus(1, 0, EMPTY, 4'd15, ex(S_WIN, 3, 0, 0, 1, 1, 0), "win_hold");
        applyStimulus(0, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 1, 0, 0, 0), "restart_from_win");
        serveToPlay(3);
        applyStimulus(1, 0, FULL, 4'd15, ex(S_MISS, 3, 0, 0, 1, 0, 0), "miss_before_reset");
        applyStimulus(0, 0, FULL, 4'd0, ex(S_SERVE, 2, 0, 1, 1, 0, 0), "reserve_before_reset");
        serveToPlay(2);

        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_mid_play", ex(S_IDLE, 0, 0, 0, 1, 0, 0));
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1, 0, FULL, 4'd15, ex(S_IDLE, 0, 0, 0, 1, 0, 0), "idle_after_reset");
        applyStimulus(0, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 1, 0, 0, 0), "start_after_reset");
        serveToPlay(3);
        applyStimulus(0, 0, EMPTY, 4'd0, ex(S_WIN, 3, 0, 0, 1, 1, 0), "win_without_tick");

`ifdef GAME_SEQUENCER_PAUSE_EN
        applyStimulus(0, 1, FULL, 4'd0, ex(S_SERVE, 3, 0, 1, 0, 0, 0), "restart_for_pause");
        serveToPlay(3);
        pauseStep(1, 0, 0, FULL, 4'd0, ex(3'd6, 3, 0, 0, 1, 0, 0), "pause_enter");
        pauseStep(0, 1, 1, FULL, 4'd15, ex(3'd6, 3, 0, 0, 1, 0, 0), "pause_miss_ignored");
        pauseStep(0, 0, 0, EMPTY, 4'd0, ex(3'd6, 3, 0, 0, 1, 0, 0), "pause_win_ignored");
        pauseStep(1, 0, 0, FULL, 4'd0, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "pause_exit");
        pauseStep(1, 0, 0, FULL, 4'd0, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "pause_held_no_edge");
        pauseStep(0, 0, 0, FULL, 4'd0, ex(S_PLAY, 3, 1, 0, 1, 0, 0), "pause_released");
`endif

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
